// File: rtl/loader_pkg.sv
// Shared types and framing constants for the UART program loader.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_HDR   = 3'd1,
        ST_DATA  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4
    } loader_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int START_BITS     = 1;
    localparam int DATA_BITS      = 8;
    localparam int STOP_BITS      = 1;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: input synchronizer, start-bit glitch filter, mid-bit sampling.
module uart_rx_byte
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W = $clog2(DATA_BITS);
    // Edge detection already costs one cycle, so the half-bit wait is shortened by one.
    localparam logic [CNT_W-1:0] HALF_CNT = CNT_W'(CLKS_PER_BIT / 2 - 2);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        st;
    logic [CNT_W-1:0] cnt;
    logic [BIT_W-1:0] bit_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta    <= 1'b1;
            rx_sync    <= 1'b1;
            rx_prev    <= 1'b1;
            st         <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_data  <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_meta    <= rx;
            rx_sync    <= rx_meta;
            rx_prev    <= rx_sync;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (st)
                RX_IDLE: begin
                    if (rx_prev && !rx_sync) begin
                        st  <= RX_START;
                        cnt <= '0;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_CNT) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (cnt == FULL_CNT) begin
                        cnt       <= '0;
                        byte_data <= {rx_sync, byte_data[7:1]};
                        bit_idx   <= bit_idx + 1'b1;
                        if (bit_idx == LAST_BIT) st <= RX_STOP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (cnt == FULL_CNT) begin
                        cnt        <= '0;
                        st         <= RX_IDLE;
                        byte_valid <= rx_sync;
                        frame_err  <= !rx_sync;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: receives a length-prefixed program image over UART and writes it to imem.
module uart_prog_loader
    import loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10417,
    parameter int ADDR_W       = 14
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              uart_rx,
    input  logic              load_start,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    loader_state_t   state, state_nx;
    logic            byte_valid, frame_err;
    logic [7:0]      byte_data;
    logic [1:0]      byte_cnt;
    logic [7:0]      hdr_lo;
    logic [15:0]     n_words;
    logic [15:0]     hdr_full;
    logic [ADDR_W:0] idx, idx_inc;
    logic [31:0]     word;
    logic            hdr_too_big, hdr_zero, last_word, start_ok;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (uart_rx),
        .byte_valid(byte_valid),
        .byte_data (byte_data),
        .frame_err (frame_err)
    );

    assign hdr_full    = {byte_data, hdr_lo};
    assign hdr_too_big = 32'(hdr_full) > (32'd1 << ADDR_W);
    assign hdr_zero    = (hdr_full == 16'd0);
    assign idx_inc     = idx + 1'b1;
    // Index is one bit wider than the address so a full 2^ADDR_W image terminates.
    assign last_word   = 32'(idx_inc) == 32'(n_words);
    assign start_ok    = load_start && (state == ST_IDLE || state == ST_ERR);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (load_start) state_nx = ST_HDR;
            ST_HDR: begin
                if (frame_err) state_nx = ST_ERR;
                else if (byte_valid && byte_cnt == 2'(HDR_BYTES - 1)) begin
                    if (hdr_too_big)   state_nx = ST_ERR;
                    else if (hdr_zero) state_nx = ST_IDLE;
                    else               state_nx = ST_DATA;
                end
            end
            ST_DATA: begin
                if (frame_err) state_nx = ST_ERR;
                else if (byte_valid && byte_cnt == 2'(BYTES_PER_WORD - 1)) state_nx = ST_WRITE;
            end
            ST_WRITE: state_nx = last_word ? ST_IDLE : ST_DATA;
            ST_ERR:   if (load_start) state_nx = ST_HDR;
            default:  state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        imem_we   = 1'b0;
        cpu_rst_n = 1'b0;
        busy      = 1'b0;
        case (state)
            ST_IDLE:  cpu_rst_n = 1'b1;
            ST_HDR:   busy = 1'b1;
            ST_DATA:  busy = 1'b1;
            ST_WRITE: begin
                busy    = 1'b1;
                imem_we = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            hdr_lo   <= '0;
            n_words  <= '0;
            idx      <= '0;
            word     <= '0;
        end else if (start_ok) begin
            done     <= 1'b0;
            err      <= 1'b0;
            byte_cnt <= '0;
            idx      <= '0;
        end else begin
            if (state != ST_IDLE && state_nx == ST_IDLE) done <= 1'b1;
            if (state != ST_ERR && state_nx == ST_ERR)   err  <= 1'b1;
            case (state)
                ST_HDR: if (byte_valid) begin
                    if (byte_cnt == 2'd0) begin
                        hdr_lo   <= byte_data;
                        byte_cnt <= byte_cnt + 1'b1;
                    end else begin
                        n_words  <= hdr_full;
                        byte_cnt <= '0;
                    end
                end
                ST_DATA: if (byte_valid) begin
                    word     <= {byte_data, word[31:8]};
                    byte_cnt <= byte_cnt + 1'b1;
                end
                ST_WRITE: idx <= idx_inc;
                default: ;
            endcase
        end
    end

    assign imem_addr  = idx[ADDR_W-1:0];
    assign imem_wdata = word;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench for uart_prog_loader with CLKS_PER_BIT=4, ADDR_W=4.
module tb_uart_prog_loader;

    localparam int CPB = 4;
    localparam int AW  = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          uart_rx = 1'b1;
    logic          load_start = 1'b0;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_rst_n, busy, done, err;

    int checks = 0;
    int errors = 0;

    // Write log filled by the monitor, plus the outputs seen one cycle after each write.
    int          wr_n = 0;
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic        post_rst [16];
    logic        post_done [16];
    logic        post_we [16];
    bit          post_pending = 0;

    uart_prog_loader #(.CLKS_PER_BIT(CPB), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .uart_rx   (uart_rx),
        .load_start(load_start),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_wdata(imem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (post_pending && wr_n > 0) begin
            post_rst[(wr_n-1) % 16]  = cpu_rst_n;
            post_done[(wr_n-1) % 16] = done;
            post_we[(wr_n-1) % 16]   = imem_we;
            post_pending = 0;
        end
        if (imem_we) begin
            wr_addr[wr_n % 16] = 32'(imem_addr);
            wr_data[wr_n % 16] = imem_wdata;
            wr_n = wr_n + 1;
            post_pending = 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            errors = errors + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 load_start = 1'b1;
        @(posedge clk); #1 load_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rx = 1'b0;
        repeat (CPB) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(posedge clk);
            #1;
        end
        uart_rx = stop;
        repeat (CPB) @(posedge clk);
        #1 uart_rx = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic send_image();
        logic [7:0] img [10];
        img = '{8'h02, 8'h00, 8'h13, 8'h05, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        for (int i = 0; i < 10; i++) send_byte(img[i], 1'b1);
        repeat (4) @(posedge clk);
    endtask

    initial begin
        int base;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_we", 32'(imem_we), 0);
        check("rst_addr", 32'(imem_addr), 0);
        check("rst_wdata", imem_wdata, 0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_err", 32'(err), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Normal two-word load
        pulse_start();
        @(negedge clk);
        check("ld_cpu_rst_low", 32'(cpu_rst_n), 0);
        check("ld_busy", 32'(busy), 1);
        send_image();
        check("ld_wr_count", 32'(wr_n), 2);
        check("ld_addr0", wr_addr[0], 0);
        check("ld_data0", wr_data[0], 32'h0000_0513);
        check("ld_addr1", wr_addr[1], 1);
        check("ld_data1", wr_data[1], 32'h0010_0093);
        check("ld_post0_cpu_rst", 32'(post_rst[0]), 0);
        check("ld_post1_cpu_rst", 32'(post_rst[1]), 1);
        check("ld_post1_done", 32'(post_done[1]), 1);
        check("ld_post1_we", 32'(post_we[1]), 0);

        // Zero-length header
        base = wr_n;
        pulse_start();
        @(negedge clk);
        check("z_done_clear", 32'(done), 0);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        check("z_done", 32'(done), 1);
        check("z_cpu_rst_n", 32'(cpu_rst_n), 1);
        check("z_no_write", 32'(wr_n - base), 0);

        // Oversize header (17 > 16)
        pulse_start();
        send_byte(8'h11, 1'b1);
        send_byte(8'h00, 1'b1);
        check("big_err", 32'(err), 1);
        check("big_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("big_busy", 32'(busy), 0);
        check("big_no_write", 32'(wr_n - base), 0);
        pulse_start();
        @(negedge clk);
        check("big_err_clear", 32'(err), 0);
        check("big_hdr_busy", 32'(busy), 1);

        // Framing error on the third data byte (already in HDR)
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        check("fe_err", 32'(err), 1);
        check("fe_cpu_rst_n", 32'(cpu_rst_n), 0);
        check("fe_no_write", 32'(wr_n - base), 0);

        // One-cycle glitch mid-word is ignored
        pulse_start();
        send_byte(8'h01, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        uart_rx = 1'b0;
        @(posedge clk); #1 uart_rx = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("gl_busy", 32'(busy), 1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        repeat (4) @(posedge clk);
        check("gl_wr_count", 32'(wr_n - base), 1);
        check("gl_addr", wr_addr[base % 16], 0);
        check("gl_data", wr_data[base % 16], 32'h0000_0513);
        check("gl_done", 32'(done), 1);

        // Reset after 5 of 8 data bytes, then reload from scratch
        base = wr_n;
        pulse_start();
        send_byte(8'h02, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_byte(8'h05, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h00, 1'b1);
        send_byte(8'h93, 1'b1);
        check("mr_partial_writes", 32'(wr_n - base), 1);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mr_we", 32'(imem_we), 0);
        check("mr_addr", 32'(imem_addr), 0);
        check("mr_wdata", imem_wdata, 0);
        check("mr_cpu_rst_n", 32'(cpu_rst_n), 1);
        check("mr_busy", 32'(busy), 0);
        check("mr_done", 32'(done), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        base = wr_n;
        pulse_start();
        send_image();
        check("mr_wr_count", 32'(wr_n - base), 2);
        check("mr_addr0", wr_addr[base % 16], 0);
        check("mr_data0", wr_data[base % 16], 32'h0000_0513);
        check("mr_addr1", wr_addr[(base + 1) % 16], 1);
        check("mr_data1", wr_data[(base + 1) % 16], 32'h0010_0093);
        check("mr_done_end", 32'(done), 1);
        check("mr_cpu_rst_end", 32'(cpu_rst_n), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
